// File: rtl/uart_rx_ctrl_if.sv
// Host read port of the UART receive controller: valid/ready handshake carrying one
// captured frame (data plus {stop, start, parity} error bits).
interface uart_rx_ctrl_if;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [2:0] rd_err;

  modport master (output rd_valid, output rd_data, output rd_err, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_err, output rd_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: between-frame config apply, frame FIFO with host read port,
// overrun/error statistics. Define UART_RX_CTRL_DROP_ERR_EN to drop errored frames.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rx_enable,
  input  logic                   cfg_write,
  input  logic [1:0]             cfg_baud_rate,
  input  logic [1:0]             cfg_parity_type,
  input  logic                   rx_active_flag,
  input  logic                   rx_done_flag,
  input  logic [2:0]             rx_error_flag,
  input  logic [7:0]             rx_data,
  output logic [1:0]             baud_rate,
  output logic [1:0]             parity_type,
  output logic                   rx_reset_n,
  output logic                   cfg_busy,
  uart_rx_ctrl_if.master         rd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overrun,
  output logic [CNT_W-1:0]       err_count,
  input  logic                   clr_status
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);
`ifdef UART_RX_CTRL_DROP_ERR_EN
  localparam bit DropErr = 1'b1;
`else
  localparam bit DropErr = 1'b0;
`endif

  typedef enum logic [1:0] {StCfgIdle, StCfgWait, StCfgApply} cfg_state_e;

  cfg_state_e state_q, state_d;
  logic       applying;

  logic            done_q;
  logic [1:0]      baud_q, parity_q, pend_baud_q, pend_parity_q;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic [10:0]     mem_q [DEPTH];
  logic            overrun_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic done_rise, capture, has_err, store, empty, full;
  logic do_read, do_write, overrun_set, err_inc;

  assign done_rise   = rx_done_flag & ~done_q;
  assign capture     = done_rise & rx_enable & ~applying;
  assign has_err     = |rx_error_flag;
  assign store       = capture & ~(DropErr & has_err);
  assign empty       = (count_q == '0);
  assign full        = (count_q == Full);
  assign do_read     = ~empty & rd.rd_ready;
  // A full FIFO still takes the frame when the head leaves in the same cycle.
  assign do_write    = store & (~full | do_read);
  assign overrun_set = store & full & ~do_read;
  assign err_inc     = capture & has_err;

  // Config FSM: state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= StCfgIdle;
    else          state_q <= state_d;
  end

  // Config FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StCfgIdle:  if (cfg_write) state_d = StCfgWait;
      StCfgWait:  if (!rx_active_flag && !done_rise) state_d = StCfgApply;
      StCfgApply: state_d = cfg_write ? StCfgWait : StCfgIdle;
      default:    state_d = StCfgIdle;
    endcase
  end

  // Config FSM: outputs
  always_comb begin
    applying   = (state_q == StCfgApply);
    cfg_busy   = (state_q != StCfgIdle);
    rx_reset_n = (state_q != StCfgApply);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done_q        <= 1'b0;
      baud_q        <= 2'b00;
      parity_q      <= 2'b00;
      pend_baud_q   <= 2'b00;
      pend_parity_q <= 2'b00;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      overrun_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      done_q <= rx_done_flag;
      if (cfg_write) begin
        pend_baud_q   <= cfg_baud_rate;
        pend_parity_q <= cfg_parity_type;
      end
      if (applying) begin
        baud_q   <= pend_baud_q;
        parity_q <= pend_parity_q;
      end
      if (do_write) wptr_q <= wptr_q + 1'b1;
      if (do_read)  rptr_q <= rptr_q + 1'b1;
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (overrun_set)     overrun_q <= 1'b1;
      else if (clr_status) overrun_q <= 1'b0;
      if (clr_status)                   err_cnt_q <= '0;
      else if (err_inc && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  // Storage needs no reset: the read port is gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (do_write) mem_q[wptr_q] <= {(DropErr ? 3'b000 : rx_error_flag), rx_data};
  end

  assign rd.rd_valid = ~empty;
  assign rd.rd_data  = empty ? 8'h00 : mem_q[rptr_q][7:0];
  assign rd.rd_err   = empty ? 3'b000 : mem_q[rptr_q][10:8];
  assign fifo_count  = count_q;
  assign overrun     = overrun_q;
  assign err_count   = err_cnt_q;
  assign baud_rate   = baud_q;
  assign parity_type = parity_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clock = 1'b0;
  logic       reset_n, rx_enable, cfg_write, rx_active_flag, rx_done_flag, clr_status;
  logic [1:0] cfg_baud_rate, cfg_parity_type, baud_rate, parity_type;
  logic [2:0] rx_error_flag;
  logic [7:0] rx_data;
  logic       rx_reset_n, cfg_busy, overrun;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] err_count;

  uart_rx_ctrl_if rd_if ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .rx_enable       (rx_enable),
    .cfg_write       (cfg_write),
    .cfg_baud_rate   (cfg_baud_rate),
    .cfg_parity_type (cfg_parity_type),
    .rx_active_flag  (rx_active_flag),
    .rx_done_flag    (rx_done_flag),
    .rx_error_flag   (rx_error_flag),
    .rx_data         (rx_data),
    .baud_rate       (baud_rate),
    .parity_type     (parity_type),
    .rx_reset_n      (rx_reset_n),
    .cfg_busy        (cfg_busy),
    .rd              (rd_if.master),
    .fifo_count      (fifo_count),
    .overrun         (overrun),
    .err_count       (err_count),
    .clr_status      (clr_status)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {logic [2:0] err; logic [7:0] data;} ent_t;
  ent_t mq[$];
  bit   m_init = 0;
  bit   m_done_q, m_overrun, m_pending, m_apply;
  int   m_errc;
  logic [1:0] m_pb, m_pp, m_baud, m_par;

  always @(posedge clock) begin
    bit rise, cap, bad, store, was_full, rd, ovr;
    if (!reset_n) begin
      mq.delete();
      m_done_q = 0; m_overrun = 0; m_errc = 0; m_pending = 0; m_apply = 0;
      m_baud = 0; m_par = 0; m_pb = 0; m_pp = 0;
      m_init = 1;
    end else if (m_init) begin
      rise  = rx_done_flag && !m_done_q;
      cap   = rise && rx_enable && !m_apply;
      bad   = (rx_error_flag != 0);
`ifdef UART_RX_CTRL_DROP_ERR_EN
      store = cap && !bad;
`else
      store = cap;
`endif
      was_full = (mq.size() == DEPTH);
      rd    = (mq.size() != 0) && rd_if.rd_ready;
      ovr   = 0;
      if (rd) void'(mq.pop_front());
      if (store) begin
        if (!was_full || rd) mq.push_back('{err: rx_error_flag, data: rx_data});
        else ovr = 1;
      end
      if (ovr) m_overrun = 1;
      else if (clr_status) m_overrun = 0;
      if (clr_status) m_errc = 0;
      else if (cap && bad && m_errc < CNT_MAX) m_errc++;
      // configuration: a pending request is applied in a dedicated cycle once the line is idle
      if (m_apply) begin
        m_baud = m_pb; m_par = m_pp; m_apply = 0;
        m_pending = cfg_write;
      end else if (m_pending) begin
        if (!rx_active_flag && !rise) begin m_apply = 1; m_pending = 0; end
      end else if (cfg_write) m_pending = 1;
      if (cfg_write) begin m_pb = cfg_baud_rate; m_pp = cfg_parity_type; end
      m_done_q = rx_done_flag;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      chk("baud_rate",   32'(baud_rate),   32'(m_baud));
      chk("parity_type", 32'(parity_type), 32'(m_par));
      chk("rx_reset_n",  32'(rx_reset_n),  32'(!m_apply));
      chk("cfg_busy",    32'(cfg_busy),    32'(m_pending || m_apply));
      chk("rd_valid",    32'(rd_if.rd_valid), 32'(mq.size() != 0));
      chk("rd_data",     32'(rd_if.rd_data),  (mq.size() != 0) ? 32'(mq[0].data) : 32'h0);
      chk("rd_err",      32'(rd_if.rd_err),   (mq.size() != 0) ? 32'(mq[0].err) : 32'h0);
      chk("fifo_count",  32'(fifo_count),  32'(mq.size()));
      chk("overrun",     32'(overrun),     32'(m_overrun));
      chk("err_count",   32'(err_count),   32'(m_errc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 0; cyc(); cyc(); reset_n = 1;
  endtask

  task automatic frame(input logic [7:0] d, input logic [2:0] e);
    rx_done_flag = 1; rx_data = d; rx_error_flag = e; cyc();
    rx_done_flag = 0; cyc();
  endtask

  initial begin
    reset_n = 0; rx_enable = 1; cfg_write = 0; cfg_baud_rate = 0; cfg_parity_type = 0;
    rx_active_flag = 0; rx_done_flag = 0; rx_error_flag = 0; rx_data = 0; clr_status = 0;
    rd_if.rd_ready = 0;
    cyc(); do_reset(); cyc();
    chk("reset fifo_count", 32'(fifo_count), 0);
    chk("reset rx_reset_n", 32'(rx_reset_n), 1);

    // three frames, then drain in order
    frame(8'hA5, 3'b000); frame(8'h3C, 3'b000); frame(8'hFF, 3'b000);
    chk("three fifo_count", 32'(fifo_count), 3);
    chk("three head", 32'(rd_if.rd_data), 32'hA5);
    rd_if.rd_ready = 1; cyc();
    chk("read 2", 32'(rd_if.rd_data), 32'h3C); cyc();
    chk("read 3", 32'(rd_if.rd_data), 32'hFF); cyc();
    chk("drained", 32'(rd_if.rd_valid), 0);
    rd_if.rd_ready = 0;

    // overflow, then full + read + write in one cycle
    do_reset();
    for (int i = 0; i < 9; i++) frame(8'(8'h40 + i), 3'b000);
    chk("ovf count", 32'(fifo_count), 8);
    chk("ovf flag", 32'(overrun), 1);
    rx_done_flag = 1; rx_data = 8'h99; rd_if.rd_ready = 1; cyc();
    rx_done_flag = 0; rd_if.rd_ready = 0;
    chk("full rw count", 32'(fifo_count), 8);
    chk("full rw head", 32'(rd_if.rd_data), 32'h41);
    chk("full rw overrun", 32'(overrun), 1);
    cyc();

    // config held off while receiver is active
    do_reset();
    rx_active_flag = 1; cfg_write = 1; cfg_baud_rate = 2'b10; cfg_parity_type = 2'b01; cyc();
    cfg_write = 0;
    repeat (20) cyc();
    chk("cfg held baud", 32'(baud_rate), 0);
    chk("cfg held busy", 32'(cfg_busy), 1);
    rx_active_flag = 0; cyc();
    chk("cfg apply rst", 32'(rx_reset_n), 0); cyc();
    chk("cfg applied rst", 32'(rx_reset_n), 1);
    chk("cfg applied baud", 32'(baud_rate), 2);
    chk("cfg applied par", 32'(parity_type), 1);
    chk("cfg applied busy", 32'(cfg_busy), 0);

    // last write wins
    rx_active_flag = 1; cfg_write = 1; cfg_baud_rate = 2'b01; cfg_parity_type = 2'b01; cyc();
    cfg_baud_rate = 2'b11; cfg_parity_type = 2'b11; cyc();
    cfg_write = 0; rx_active_flag = 0; cyc(); cyc();
    chk("last wins baud", 32'(baud_rate), 3);
    chk("last wins par", 32'(parity_type), 3);

    // error statistics and saturation
    do_reset();
    frame(8'h10, 3'b001);
`ifndef UART_RX_CTRL_DROP_ERR_EN
    chk("err head 1", 32'(rd_if.rd_err), 1);
`endif
    frame(8'h20, 3'b100);
    chk("err_count 2", 32'(err_count), 2);
`ifndef UART_RX_CTRL_DROP_ERR_EN
    rd_if.rd_ready = 1; cyc(); rd_if.rd_ready = 0;
    chk("err head 2", 32'(rd_if.rd_err), 3'b100);
    chk("err head 2 data", 32'(rd_if.rd_data), 32'h20);
`endif
    for (int i = 0; i < CNT_MAX - 2; i++) frame(8'(i), 3'b010);
    chk("err sat", 32'(err_count), CNT_MAX);
    frame(8'h00, 3'b010);
    chk("err sat hold", 32'(err_count), CNT_MAX);
    clr_status = 1; cyc(); clr_status = 0;
    chk("err clr", 32'(err_count), 0);
    chk("ovr clr", 32'(overrun), 0);

`ifdef UART_RX_CTRL_DROP_ERR_EN
    do_reset();
    frame(8'h11, 3'b000); frame(8'h22, 3'b010); frame(8'h33, 3'b000);
    chk("drop count", 32'(fifo_count), 2);
    chk("drop head", 32'(rd_if.rd_data), 32'h11);
    chk("drop errc", 32'(err_count), 1);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2) == 0) rx_done_flag = ~rx_done_flag;
      rx_data        = 8'($urandom);
      rx_error_flag  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      rx_enable      = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) rx_active_flag = ~rx_active_flag;
      cfg_write      = ($urandom_range(0, 19) == 0);
      cfg_baud_rate  = 2'($urandom);
      cfg_parity_type = 2'($urandom);
      rd_if.rd_ready = (i < 3000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_status     = ($urandom_range(0, 99) == 0);
      reset_n        = ($urandom_range(0, 499) != 0);
      cyc();
    end
    reset_n = 1; cfg_write = 0; clr_status = 0; rx_done_flag = 0; rd_if.rd_ready = 0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
